// File: rtl/masked_parallel_mul_feeder_pkg.sv
// Shared constants, FSM state type and helpers for the masked multiplier feeder.
package masked_parallel_mul_feeder_pkg;

   localparam logic [63:0] DEFAULT_SEED = 64'h9E37_79B9_7F4A_7C15;

   typedef enum logic {
      FEED_WARMUP = 1'b0,
      FEED_RUN    = 1'b1
   } feeder_state_t;

   // Number of pairwise cross terms, i.e. fresh masks needed per multiplication.
   function automatic int num_quad(input int num_shares);
      return (num_shares * (num_shares - 1)) / 2;
   endfunction

   function automatic logic [63:0] xorshift64_step(input logic [63:0] x);
      logic [63:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
      return y;
   endfunction

endpackage

// File: rtl/masked_prng_xorshift64.sv
// xorshift64 generator: steps every cycle, loads a seed on request (zero seed maps to DEFAULT_SEED).
module masked_prng_xorshift64
   import masked_parallel_mul_feeder_pkg::*;
#(
   parameter int OUT_W = 12
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [63:0]      i_seed,
   output logic [OUT_W-1:0] o_rand
);

   logic [63:0] r_state;

   // An all-zero state is a fixed point of xorshift, so it is never loaded.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= DEFAULT_SEED;
      end else if (i_load) begin
         r_state <= (i_seed == 64'd0) ? DEFAULT_SEED : i_seed;
      end else begin
         r_state <= xorshift64_step(r_state);
      end
   end

   assign o_rand = r_state[OUT_W-1:0];

endmodule

// File: rtl/masked_parallel_mul_feeder.sv
// Feeder for the parallel HPC3 multiplier pair: b,c issued at t0, a and fresh randomness at t1.
// Build option MASKED_FEEDER_ZERO_RAND_EN: randomness tied to zero, no PRNG, no warmup (debug only).
module masked_parallel_mul_feeder
   import masked_parallel_mul_feeder_pkg::*;
#(
   parameter  int NUM_SHARES    = 2,
   parameter  int BIT_WIDTH     = 4,
   parameter  int MUL_LATENCY   = 1,
   parameter  int WARMUP_CYCLES = 16,
   localparam int NUM_QUADRATIC = num_quad(NUM_SHARES),
   localparam int SHARE_W       = NUM_SHARES * BIT_WIDTH,
   localparam int RAND_W        = NUM_QUADRATIC * BIT_WIDTH
)(
   input  logic               in_clock,
   input  logic               in_reset,
   input  logic [SHARE_W-1:0] in_a,
   input  logic [SHARE_W-1:0] in_b,
   input  logic [SHARE_W-1:0] in_c,
   input  logic               in_valid,
   output logic               out_ready,
   input  logic [63:0]        in_seed,
   input  logic               in_seed_load,
   output logic [SHARE_W-1:0] out_b_t0,
   output logic [SHARE_W-1:0] out_c_t0,
   output logic [SHARE_W-1:0] out_a_t1,
   output logic [RAND_W-1:0]  out_r,
   output logic [RAND_W-1:0]  out_p_ab,
   output logic [RAND_W-1:0]  out_p_ac,
   output logic               out_result_valid,
   output logic               out_busy,
   output feeder_state_t      out_dbg_state
);

   if (3 * RAND_W > 64) begin : g_bad_rand_width
      $error("randomness width 3*NUM_QUADRATIC*BIT_WIDTH exceeds the 64-bit PRNG state");
   end
   if (MUL_LATENCY < 1) begin : g_bad_latency
      $error("MUL_LATENCY must be at least 1");
   end
   if (WARMUP_CYCLES < 1) begin : g_bad_warmup
      $error("WARMUP_CYCLES must be at least 1");
   end

   // Without a PRNG, WARMUP lasts a single cycle so out_ready stays low while reset is held.
`ifdef MASKED_FEEDER_ZERO_RAND_EN
   localparam int WARM_LEN = 1;
`else
   localparam int WARM_LEN = WARMUP_CYCLES;
`endif
   localparam int              CNT_W    = (WARM_LEN > 1) ? $clog2(WARM_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARM_LEN - 1);

   feeder_state_t          r_state;
   feeder_state_t          w_state_next;
   logic [CNT_W-1:0]       r_warm_cnt;
   logic [CNT_W-1:0]       w_warm_cnt_next;
   logic                   w_ready;
   logic                   w_accept;
   logic [3*RAND_W-1:0]    w_rand;

   logic                   r_t0_valid;
   logic [SHARE_W-1:0]     r_a_t0;
   logic [SHARE_W-1:0]     r_b_t0;
   logic [SHARE_W-1:0]     r_c_t0;
   logic                   r_t1_valid;
   logic [SHARE_W-1:0]     r_a_t1;
   logic [MUL_LATENCY-1:0] r_lat_valid;

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         r_state    <= FEED_WARMUP;
         r_warm_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_warm_cnt <= w_warm_cnt_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_warm_cnt_next = r_warm_cnt;
      w_ready         = 1'b0;
      case (r_state)
         FEED_WARMUP: begin
            if (r_warm_cnt == CNT_LAST) begin
               w_state_next    = FEED_RUN;
               w_warm_cnt_next = '0;
            end else begin
               w_warm_cnt_next = r_warm_cnt + CNT_W'(1);
            end
         end
         FEED_RUN: w_ready = !in_seed_load;
         default:  w_state_next = FEED_WARMUP;
      endcase
      // A reseed restarts warmup from any state; the PRNG reloads on the same edge.
      if (in_seed_load) begin
         w_state_next    = FEED_WARMUP;
         w_warm_cnt_next = '0;
      end
   end

   assign w_accept = in_valid && w_ready;

   // Slots always advance; an empty slot loads zeros so no stale share survives.
   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         r_t0_valid  <= 1'b0;
         r_a_t0      <= '0;
         r_b_t0      <= '0;
         r_c_t0      <= '0;
         r_t1_valid  <= 1'b0;
         r_a_t1      <= '0;
         r_lat_valid <= '0;
      end else begin
         r_t0_valid     <= w_accept;
         r_a_t0         <= w_accept ? in_a : '0;
         r_b_t0         <= w_accept ? in_b : '0;
         r_c_t0         <= w_accept ? in_c : '0;
         r_t1_valid     <= r_t0_valid;
         r_a_t1         <= r_a_t0;
         r_lat_valid[0] <= r_t1_valid;
         for (int i = 1; i < MUL_LATENCY; i++) begin
            r_lat_valid[i] <= r_lat_valid[i-1];
         end
      end
   end

`ifdef MASKED_FEEDER_ZERO_RAND_EN
   assign w_rand = '0;
`else
   masked_prng_xorshift64 #(
      .OUT_W (3 * RAND_W)
   ) u_prng (
      .i_clk  (in_clock),
      .i_rst  (in_reset),
      .i_load (in_seed_load),
      .i_seed (in_seed),
      .o_rand (w_rand)
   );
`endif

   assign out_ready        = w_ready;
   assign out_b_t0         = r_b_t0;
   assign out_c_t0         = r_c_t0;
   assign out_a_t1         = r_a_t1;
   assign out_r            = r_t1_valid ? w_rand[RAND_W-1:0]          : '0;
   assign out_p_ab         = r_t1_valid ? w_rand[2*RAND_W-1:RAND_W]   : '0;
   assign out_p_ac         = r_t1_valid ? w_rand[3*RAND_W-1:2*RAND_W] : '0;
   assign out_result_valid = r_lat_valid[MUL_LATENCY-1];
   assign out_busy         = r_t0_valid | r_t1_valid | (|r_lat_valid);
   assign out_dbg_state    = r_state;

endmodule

// File: tb/tb_masked_parallel_mul_feeder.sv
// Self-checking bench for masked_parallel_mul_feeder: schedule-based model plus directed literal checks.
module tb_masked_parallel_mul_feeder;
  import masked_parallel_mul_feeder_pkg::*;

  localparam int SW   = 8;
  localparam int RW   = 4;
  localparam int LAT  = 1;
  localparam int WARM = 16;
  localparam logic [63:0] DEF_SEED = 64'h9E3779B97F4A7C15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [SW-1:0] a = '0, b = '0, c = '0;
  logic          valid = 1'b0;
  logic [63:0]   seed = '0;
  logic          load = 1'b0;

  logic          out_ready, out_result_valid, out_busy;
  logic [SW-1:0] out_b_t0, out_c_t0, out_a_t1;
  logic [RW-1:0] out_r, out_p_ab, out_p_ac;
  feeder_state_t out_dbg_state;

  masked_parallel_mul_feeder dut (
    .in_clock(clk), .in_reset(rst),
    .in_a(a), .in_b(b), .in_c(c), .in_valid(valid), .out_ready(out_ready),
    .in_seed(seed), .in_seed_load(load),
    .out_b_t0(out_b_t0), .out_c_t0(out_c_t0), .out_a_t1(out_a_t1),
    .out_r(out_r), .out_p_ab(out_p_ab), .out_p_ac(out_p_ac),
    .out_result_valid(out_result_valid), .out_busy(out_busy),
    .out_dbg_state(out_dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] prng_next(input logic [63:0] x);
    logic [63:0] s;
    s = x ^ (x << 13);
    s = s ^ (s >> 7);
    s = s ^ (s << 17);
    return s;
  endfunction

  // ---------------- behavioural model ----------------
  // Items are scheduled by absolute cycle number: t0 at k+1, t1 at k+2, result at k+2+LAT.
  int            m_cyc  = 0;
  int            m_warm = WARM;
  logic [63:0]   m_prng = DEF_SEED;
  logic [SW-1:0] sch_b[int];
  logic [SW-1:0] sch_c[int];
  bit            sch_t1[int];
  bit            sch_res[int];
  bit            sch_busy[int];
  logic [SW-1:0] exp_q[$];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_warm = WARM;
        m_prng = DEF_SEED;
        sch_b.delete(); sch_c.delete(); sch_t1.delete();
        sch_res.delete(); sch_busy.delete(); exp_q.delete();
      end else begin
        if (valid && m_warm == 0 && !load) begin
          sch_b[m_cyc+1] = b;
          sch_c[m_cyc+1] = c;
          sch_t1[m_cyc+2] = 1'b1;
          sch_res[m_cyc+2+LAT] = 1'b1;
          for (int j = m_cyc + 1; j <= m_cyc + 2 + LAT; j++) sch_busy[j] = 1'b1;
          exp_q.push_back(a);
        end
        if (load) begin
          m_prng = (seed == 64'd0) ? DEF_SEED : seed;
          m_warm = WARM;
        end else begin
          m_prng = prng_next(m_prng);
          if (m_warm > 0) m_warm--;
        end
        m_cyc++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit             collect = 1'b0;
  logic [3*RW-1:0] fresh_q[$];

  initial begin
    logic [SW-1:0] ea, eb, ec;
    logic [RW-1:0] er, eab, eac;
    logic          t1;
    forever begin
      @(negedge clk);
      t1 = sch_t1.exists(m_cyc);
      eb = sch_b.exists(m_cyc) ? sch_b[m_cyc] : '0;
      ec = sch_c.exists(m_cyc) ? sch_c[m_cyc] : '0;
      ea = '0;
      if (t1 && exp_q.size() > 0) ea = exp_q.pop_front();
      er  = t1 ? m_prng[RW-1:0]      : '0;
      eab = t1 ? m_prng[2*RW-1:RW]   : '0;
      eac = t1 ? m_prng[3*RW-1:2*RW] : '0;
      chk("ready",        64'(out_ready), 64'((m_warm == 0) && !load));
      chk("state",        64'(out_dbg_state), 64'((m_warm == 0) ? FEED_RUN : FEED_WARMUP));
      chk("b_t0",         64'(out_b_t0), 64'(eb));
      chk("c_t0",         64'(out_c_t0), 64'(ec));
      chk("a_t1",         64'(out_a_t1), 64'(ea));
      chk("r",            64'(out_r), 64'(er));
      chk("p_ab",         64'(out_p_ab), 64'(eab));
      chk("p_ac",         64'(out_p_ac), 64'(eac));
      chk("result_valid", 64'(out_result_valid), 64'(sch_res.exists(m_cyc)));
      chk("busy",         64'(out_busy), 64'(sch_busy.exists(m_cyc)));
      if (collect && t1) fresh_q.push_back({out_p_ac, out_p_ab, out_r});
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_ready_low(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(name, 64'(out_ready), 64'd0);
      next_cycle();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [3*RW-1:0] w_ref;
    int res_cnt, run, max_run, distinct;
    bit dup;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Reset release: out_ready low for exactly 16 cycles, outputs idle.
    for (int i = 0; i < WARM; i++) begin
      @(negedge clk);
      chk("warmup_ready_low", 64'(out_ready), 64'd0);
      chk("warmup_b_t0_zero", 64'(out_b_t0), 64'd0);
      chk("warmup_r_zero", 64'(out_r), 64'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("ready_after_warmup", 64'(out_ready), 64'd1);

    // Single item a={3,5}, b={6,9}, c={A,1}; share 0 in the low nibble.
    #1;
    a = 8'h53; b = 8'h96; c = 8'h1A; valid = 1'b1;
    next_cycle();
    valid = 1'b0; a = '0; b = '0; c = '0;
    @(negedge clk);
    chk("single_b_t0", 64'(out_b_t0), 64'h96);
    chk("single_c_t0", 64'(out_c_t0), 64'h1A);
    chk("single_a_t1_empty", 64'(out_a_t1), 64'h0);
    next_cycle();
    @(negedge clk);
    chk("single_a_t1", 64'(out_a_t1), 64'h53);
    chk("single_b_t0_cleared", 64'(out_b_t0), 64'h0);
    w_ref = m_prng[3*RW-1:0];
    next_cycle();
    @(negedge clk);
    chk("single_result_valid", 64'(out_result_valid), 64'd1);
    chk("single_a_t1_cleared", 64'(out_a_t1), 64'h0);
    chk("single_busy_lat", 64'(out_busy), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("single_idle_busy", 64'(out_busy), 64'd0);
    next_cycle();

    // Eight back-to-back triplets; results must form one run of 8.
    res_cnt = 0; run = 0; max_run = 0;
    for (int i = 0; i < 20; i++) begin
      valid = (i < 8);
      a = (i < 8) ? 8'(8'h10 + i) : '0;
      b = (i < 8) ? 8'(8'hF0 - i) : '0;
      c = (i < 8) ? 8'(8'h07 + 16 * i) : '0;
      @(negedge clk);
      if (out_result_valid) begin
        res_cnt++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      next_cycle();
    end
    valid = 1'b0;
    chk("burst_result_count", 64'(res_cnt), 64'd8);
    chk("burst_result_run", 64'(max_run), 64'd8);

    // Zero seed load: warmup again and the randomness sequence restarts.
    seed = 64'd0; load = 1'b1;
    @(negedge clk);
    chk("ready_low_during_load", 64'(out_ready), 64'd0);
    next_cycle();
    load = 1'b0;
    expect_ready_low(WARM, "reseed_ready_low");
    @(negedge clk);
    chk("reseed_ready_high", 64'(out_ready), 64'd1);
    #1;
    a = 8'h53; b = 8'h96; c = 8'h1A; valid = 1'b1;
    next_cycle();
    valid = 1'b0; a = '0; b = '0; c = '0;
    next_cycle();
    @(negedge clk);
    chk("reseed_rand_matches_reset", 64'({out_p_ac, out_p_ab, out_r}), 64'(w_ref));
    next_cycle();

    // Nonzero seed load with two items in flight: they drain unchanged.
    a = 8'hA1; b = 8'hB2; c = 8'hC3; valid = 1'b1;
    next_cycle();
    a = 8'hD4; b = 8'hE5; c = 8'hF6;
    next_cycle();
    valid = 1'b0; a = '0; b = '0; c = '0;
    seed = 64'h0123_4567_89AB_CDEF; load = 1'b1;
    next_cycle();
    load = 1'b0;
    repeat (20) next_cycle();

    // Async reset with two items in flight.
    a = 8'h11; b = 8'h22; c = 8'h33; valid = 1'b1;
    next_cycle();
    a = 8'h44; b = 8'h55; c = 8'h66;
    next_cycle();
    valid = 1'b0; a = '0; b = '0; c = '0;
    rst = 1'b1;
    #1;
    chk("rst_b_t0_zero", 64'(out_b_t0), 64'd0);
    chk("rst_a_t1_zero", 64'(out_a_t1), 64'd0);
    chk("rst_rand_zero", 64'({out_p_ac, out_p_ab, out_r}), 64'd0);
    chk("rst_busy_zero", 64'(out_busy), 64'd0);
    chk("rst_ready_zero", 64'(out_ready), 64'd0);
    next_cycle();
    rst = 1'b0;
    res_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_result_valid) res_cnt++;
      next_cycle();
    end
    chk("no_result_after_reset", 64'(res_cnt), 64'd0);

    // Freshness: 64 consecutive issues.
    collect = 1'b1;
    for (int i = 0; i < 64; i++) begin
      valid = 1'b1;
      a = 8'(i); b = 8'(255 - i); c = 8'(i * 3);
      next_cycle();
    end
    valid = 1'b0; a = '0; b = '0; c = '0;
    repeat (4) next_cycle();
    collect = 1'b0;
    distinct = 0;
    for (int i = 0; i < fresh_q.size(); i++) begin
      dup = 1'b0;
      for (int j = 0; j < i; j++) if (fresh_q[j] == fresh_q[i]) dup = 1'b1;
      if (!dup) distinct++;
    end
    chk("fresh_issue_count", 64'(fresh_q.size()), 64'd64);
    chk("fresh_mostly_distinct", 64'(distinct >= 60), 64'd1);

    repeat (2) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
